// File: rtl/mips_pkg.sv
// mips_pkg
//    Shared definitions for the multicycle MIPS core: opcode values (also
//    used by the ALU control decoder), sequencer state encoding, ALU operand
//    B select and PC source select encodings, and the opcode class type used
//    by the DECODE transition.
//    No ports.
package mips_pkg;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // Sequencer states
   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_FETCH    = 4'd1;
   localparam logic [3:0] S_DECODE   = 4'd2;
   localparam logic [3:0] S_EXEC_R   = 4'd3;
   localparam logic [3:0] S_WB_R     = 4'd4;
   localparam logic [3:0] S_EXEC_I   = 4'd5;
   localparam logic [3:0] S_WB_I     = 4'd6;
   localparam logic [3:0] S_MEM_ADDR = 4'd7;
   localparam logic [3:0] S_MEM_RD   = 4'd8;
   localparam logic [3:0] S_WB_MEM   = 4'd9;
   localparam logic [3:0] S_MEM_WR   = 4'd10;
   localparam logic [3:0] S_BRANCH   = 4'd11;
   localparam logic [3:0] S_JUMP     = 4'd12;
   localparam logic [3:0] S_ILLEGAL  = 4'd13;

   // ALU operand B select
   localparam logic [1:0] ALUB_RT     = 2'b00;
   localparam logic [1:0] ALUB_FOUR   = 2'b01;
   localparam logic [1:0] ALUB_IMM    = 2'b10;
   localparam logic [1:0] ALUB_IMM_SH = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [2:0] {
      CLS_MEM,
      CLS_RTYPE,
      CLS_ITYPE,
      CLS_BRANCH,
      CLS_JUMP,
      CLS_ILLEGAL
   } op_class_t;

endpackage

// File: rtl/mc_op_class.sv
// mc_op_class
//    Combinational opcode classifier used to pick the state after DECODE.
//    Ports:
//       opcode    in  6  instruction opcode field
//       op_class  out    instruction class (MEM, RTYPE, ITYPE, BRANCH, JUMP, ILLEGAL)
module mc_op_class
   import mips_pkg::*;
(
   input  logic [5:0] opcode,
   output op_class_t  op_class
);

   always_comb begin
      op_class = CLS_ILLEGAL;
      case (opcode)
         OP_LW, OP_SW:                 op_class = CLS_MEM;
         OP_RTYPE:                     op_class = CLS_RTYPE;
         OP_ADDI, OP_ADDIU, OP_ANDI,
         OP_ORI, OP_XORI, OP_LUI:      op_class = CLS_ITYPE;
         OP_BEQ, OP_BNE:               op_class = CLS_BRANCH;
         OP_J:                         op_class = CLS_JUMP;
         default:                      op_class = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
//    Moore sequencer for the unpipelined multicycle MIPS core. Steps each
//    instruction through FETCH, DECODE, EXEC, MEM and WB states and drives
//    every datapath select/enable, including the ALU op code so the single
//    ALU serves PC+4, branch target, address add and the instruction op.
//    Build option: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
//       defined   - ILLEGAL state raises o_illegal and holds until reset
//       undefined - ILLEGAL is a one-cycle no-op, o_illegal tied 0
//    Ports:
//       i_clk, i_rst_n (sync, active-low), i_opcode (IR[31:26]),
//       i_memReady (memory completes access this cycle),
//       o_pcWrite, o_pcWriteCond, o_branchNe, o_pcSrc, o_iorD, o_memRead,
//       o_memWrite, o_irWrite, o_regDst, o_memToReg, o_regWrite,
//       o_aluSrcA, o_aluSrcB, o_aluOp, o_illegal
module multicycle_control
   import mips_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [5:0] i_opcode,
   input  logic       i_memReady,
   output logic       o_pcWrite,
   output logic       o_pcWriteCond,
   output logic       o_branchNe,
   output logic [1:0] o_pcSrc,
   output logic       o_iorD,
   output logic       o_memRead,
   output logic       o_memWrite,
   output logic       o_irWrite,
   output logic       o_regDst,
   output logic       o_memToReg,
   output logic       o_regWrite,
   output logic       o_aluSrcA,
   output logic [1:0] o_aluSrcB,
   output logic [5:0] o_aluOp,
   output logic       o_illegal
);

   logic [3:0] state;
   logic [3:0] state_nxt;
   logic [5:0] op_q;
   op_class_t  op_class;

   mc_op_class u_op_class (
      .opcode   (i_opcode),
      .op_class (op_class)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
         op_q  <= OP_RTYPE;
      end else begin
         state <= state_nxt;
         // The IR is only guaranteed valid in DECODE; later states use op_q.
         if (state == S_DECODE) begin
            op_q <= i_opcode;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     state_nxt = S_FETCH;
         S_FETCH:    state_nxt = i_memReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op_class)
               CLS_MEM:     state_nxt = S_MEM_ADDR;
               CLS_RTYPE:   state_nxt = S_EXEC_R;
               CLS_ITYPE:   state_nxt = S_EXEC_I;
               CLS_BRANCH:  state_nxt = S_BRANCH;
               CLS_JUMP:    state_nxt = S_JUMP;
               default:     state_nxt = S_ILLEGAL;
            endcase
         end
         S_EXEC_R:   state_nxt = S_WB_R;
         S_WB_R:     state_nxt = S_FETCH;
         S_EXEC_I:   state_nxt = S_WB_I;
         S_WB_I:     state_nxt = S_FETCH;
         // Only LW and SW reach MEM_ADDR, so anything not LW is a store.
         S_MEM_ADDR: state_nxt = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   state_nxt = i_memReady ? S_WB_MEM : S_MEM_RD;
         S_WB_MEM:   state_nxt = S_FETCH;
         S_MEM_WR:   state_nxt = i_memReady ? S_FETCH : S_MEM_WR;
         S_BRANCH:   state_nxt = S_FETCH;
         S_JUMP:     state_nxt = S_FETCH;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
         S_ILLEGAL:  state_nxt = S_ILLEGAL;
`else
         S_ILLEGAL:  state_nxt = S_FETCH;
`endif
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_pcWrite     = 1'b0;
      o_pcWriteCond = 1'b0;
      o_branchNe    = 1'b0;
      o_pcSrc       = PCSRC_ALU;
      o_iorD        = 1'b0;
      o_memRead     = 1'b0;
      o_memWrite    = 1'b0;
      o_irWrite     = 1'b0;
      o_regDst      = 1'b0;
      o_memToReg    = 1'b0;
      o_regWrite    = 1'b0;
      o_aluSrcA     = 1'b0;
      o_aluSrcB     = ALUB_RT;
      o_aluOp       = OP_RTYPE;
      o_illegal     = 1'b0;
      case (state)
         S_FETCH: begin
            o_memRead = 1'b1;
            // Gate PC/IR loads with ready so a stalled fetch cannot
            // advance the PC more than once.
            o_irWrite = i_memReady;
            o_pcWrite = i_memReady;
            o_aluSrcB = ALUB_FOUR;
            o_aluOp   = OP_ADDI;
            o_pcSrc   = PCSRC_ALU;
         end
         S_DECODE: begin
            o_aluSrcB = ALUB_IMM_SH;
            o_aluOp   = OP_ADDI;
         end
         S_EXEC_R: begin
            o_aluSrcA = 1'b1;
            o_aluSrcB = ALUB_RT;
            o_aluOp   = op_q;
         end
         S_WB_R: begin
            o_regDst   = 1'b1;
            o_regWrite = 1'b1;
         end
         S_EXEC_I: begin
            o_aluSrcA = 1'b1;
            o_aluSrcB = ALUB_IMM;
            o_aluOp   = op_q;
         end
         S_WB_I: begin
            o_regWrite = 1'b1;
         end
         S_MEM_ADDR: begin
            o_aluSrcA = 1'b1;
            o_aluSrcB = ALUB_IMM;
            o_aluOp   = OP_ADDI;
         end
         S_MEM_RD: begin
            o_iorD    = 1'b1;
            o_memRead = 1'b1;
         end
         S_WB_MEM: begin
            o_memToReg = 1'b1;
            o_regWrite = 1'b1;
         end
         S_MEM_WR: begin
            o_iorD     = 1'b1;
            o_memWrite = 1'b1;
         end
         S_BRANCH: begin
            o_aluSrcA     = 1'b1;
            o_aluSrcB     = ALUB_RT;
            o_aluOp       = op_q;
            o_pcWriteCond = 1'b1;
            o_pcSrc       = PCSRC_ALUOUT;
            o_branchNe    = (op_q == OP_BNE);
         end
         S_JUMP: begin
            o_pcWrite = 1'b1;
            o_pcSrc   = PCSRC_JUMP;
         end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
         S_ILLEGAL:  o_illegal = 1'b1;
`endif
         default: ;
      endcase
   end

endmodule
